// File: rtl/fp_formats_pkg.sv
// rtl/fp_formats_pkg.sv - shared bf16/e4m3 format constants and bf16->e4m3 stage payload types
package fp_formats_pkg;

    localparam int BF16_EXP_W = 8;
    localparam int BF16_MAN_W = 7;
    localparam int BF16_BIAS  = 127;
    localparam int E4M3_EXP_W = 4;
    localparam int E4M3_MAN_W = 3;
    localparam int E4M3_BIAS  = 7;

    localparam logic [6:0] E4M3_MAX_MAG = 7'h7E;
    localparam logic [6:0] E4M3_NAN_MAG = 7'h7F;

    typedef enum logic [2:0] {
        ZERO,
        NORMAL,
        SUBNORM,
        OVF,
        NAN
    } cvt_class_e;

    // shift is the right-shift of the 0.1mmmmmmm fraction for subnormal results (0..8)
    typedef struct packed {
        logic                  sign;
        cvt_class_e            cls;
        logic [E4M3_EXP_W-1:0] exp;
        logic [3:0]            shift;
        logic [BF16_MAN_W-1:0] man;
    } s1_pipe_t;

    // exp carries one extra bit so a rounding carry out of exponent 15 is visible to the packer
    typedef struct packed {
        logic                  sign;
        cvt_class_e            cls;
        logic [E4M3_EXP_W:0]   exp;
        logic [E4M3_MAN_W-1:0] man;
        logic                  inexact;
    } s2_pipe_t;

endpackage

// File: rtl/fp_rne_round.sv
// rtl/fp_rne_round.sv - round-to-nearest-even increment of a kept field from guard/sticky bits
module fp_rne_round #(
    parameter int W = 3
) (
    input  logic [W-1:0] field_i,
    input  logic         guard_i,
    input  logic         sticky_i,
    output logic [W-1:0] rounded_o,
    output logic         carry_o,
    output logic         inexact_o
);

    logic round_up;

    // ties go to the even neighbour: a bare guard bit only rounds up when the lsb is odd
    assign round_up  = guard_i & (sticky_i | field_i[0]);
    assign {carry_o, rounded_o} = {1'b0, field_i} + {{W{1'b0}}, round_up};
    assign inexact_o = guard_i | sticky_i;

endmodule

// File: rtl/bf16_to_e4m3_cvt.sv
// rtl/bf16_to_e4m3_cvt.sv - 3-stage bf16 -> e4m3 RNE converter; E4M3_SATURATE_EN selects +-448 on overflow
module bf16_to_e4m3_cvt
    import fp_formats_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a_bf16,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  y,
    output logic        is_inexact
);

`ifdef E4M3_SATURATE_EN
    localparam logic [6:0] OVF_MAG = E4M3_MAX_MAG;
`else
    localparam logic [6:0] OVF_MAG = E4M3_NAN_MAG;
`endif

    localparam logic signed [9:0]     BIAS_DIFF    = 10'(BF16_BIAS - E4M3_BIAS);
    localparam logic [BF16_EXP_W-1:0] EXP_ALL_ONES = '1;

    logic     stall;
    logic     s1_valid_q;
    logic     s2_valid_q;
    logic     out_valid_q;
    s1_pipe_t s1_d, s1_q;
    s2_pipe_t s2_d, s2_q;
    logic [7:0] y_d, y_q;
    logic       inexact_d, inexact_q;

    assign stall     = out_valid_q & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign is_inexact = inexact_q;

    // S1: decode and classify against the e4m3 exponent range
    logic [BF16_EXP_W-1:0] a_exp;
    logic [BF16_MAN_W-1:0] a_man;
    logic signed [9:0]     e8;
    logic signed [9:0]     neg_e8;

    assign a_exp  = a_bf16[BF16_MAN_W +: BF16_EXP_W];
    assign a_man  = a_bf16[BF16_MAN_W-1:0];
    assign e8     = $signed({2'b00, a_exp}) - BIAS_DIFF;
    assign neg_e8 = -e8;

    always_comb begin
        s1_d      = '0;
        s1_d.sign = a_bf16[15];
        s1_d.man  = a_man;
        if (a_exp == '0) begin
            s1_d.cls = ZERO;
        end else if (a_exp == EXP_ALL_ONES) begin
            s1_d.cls = (a_man != '0) ? NAN : OVF;
        end else if (e8 > 10'sd15) begin
            s1_d.cls = OVF;
        end else if (e8 > 10'sd0) begin
            s1_d.cls = NORMAL;
            s1_d.exp = e8[3:0];
        end else begin
            // beyond 8 the whole significand already sits below the guard bit
            s1_d.cls   = SUBNORM;
            s1_d.shift = (neg_e8 > 10'sd8) ? 4'd8 : neg_e8[3:0];
        end
    end

    // S2: align and round
    logic [15:0]           sub_vec;
    logic [E4M3_MAN_W-1:0] keep;
    logic                  guard;
    logic                  sticky;
    logic [E4M3_MAN_W-1:0] rounded;
    logic                  carry;
    logic                  rnd_inexact;

    always_comb begin
        sub_vec = {1'b1, s1_q.man, 8'h00} >> s1_q.shift;
        keep    = '0;
        guard   = 1'b0;
        sticky  = 1'b0;
        case (s1_q.cls)
            NORMAL: begin
                keep   = s1_q.man[6:4];
                guard  = s1_q.man[3];
                sticky = |s1_q.man[2:0];
            end
            SUBNORM: begin
                keep   = sub_vec[15:13];
                guard  = sub_vec[12];
                sticky = |sub_vec[11:0];
            end
            default: ;
        endcase
    end

    fp_rne_round #(
        .W(E4M3_MAN_W)
    ) u_rne (
        .field_i   (keep),
        .guard_i   (guard),
        .sticky_i  (sticky),
        .rounded_o (rounded),
        .carry_o   (carry),
        .inexact_o (rnd_inexact)
    );

    always_comb begin
        s2_d      = '0;
        s2_d.sign = s1_q.sign;
        s2_d.cls  = s1_q.cls;
        case (s1_q.cls)
            ZERO: s2_d.inexact = |s1_q.man;
            NORMAL: begin
                s2_d.exp     = {1'b0, s1_q.exp} + {4'b0000, carry};
                s2_d.man     = rounded;
                s2_d.inexact = rnd_inexact;
            end
            SUBNORM: begin
                // a carry out of the subnormal field lands on the smallest normal
                s2_d.exp     = {4'b0000, carry};
                s2_d.man     = rounded;
                s2_d.inexact = rnd_inexact;
            end
            OVF: s2_d.inexact = 1'b1;
            default: ;
        endcase
    end

    // S3: pack and catch overflow created by rounding
    logic [6:0] mag;
    logic       ovf;

    always_comb begin
        mag       = {s2_q.exp[3:0], s2_q.man};
        ovf       = (s2_q.cls == OVF) ||
                    ((s2_q.cls == NORMAL) && (s2_q.exp[4] || (mag == E4M3_NAN_MAG)));
        y_d       = {s2_q.sign, mag};
        inexact_d = s2_q.inexact;
        if (s2_q.cls == NAN) begin
            y_d       = {s2_q.sign, E4M3_NAN_MAG};
            inexact_d = 1'b0;
        end else if (ovf) begin
            y_d       = {s2_q.sign, OVF_MAG};
            inexact_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            s1_q        <= '0;
            s2_q        <= '0;
            y_q         <= '0;
            inexact_q   <= 1'b0;
        end else if (!stall) begin
            s1_valid_q  <= in_valid;
            s2_valid_q  <= s1_valid_q;
            out_valid_q <= s2_valid_q;
            if (in_valid) begin
                s1_q <= s1_d;
            end
            if (s1_valid_q) begin
                s2_q <= s2_d;
            end
            if (s2_valid_q) begin
                y_q       <= y_d;
                inexact_q <= inexact_d;
            end
        end
    end

endmodule

// File: tb/tb_bf16_to_e4m3_cvt.sv
// tb/tb_bf16_to_e4m3_cvt.sv - randomized and directed bench for bf16_to_e4m3_cvt against a real-valued model
module tb_bf16_to_e4m3_cvt;

`ifdef E4M3_SATURATE_EN
    localparam logic [6:0] OVF_MAG = 7'h7E;
`else
    localparam logic [6:0] OVF_MAG = 7'h7F;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_bf16;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  y;
    logic        is_inexact;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    bf16_to_e4m3_cvt dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_bf16     (a_bf16),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y          (y),
        .is_inexact (is_inexact)
    );

    function automatic real pow2(input int n);
        real r;
        r = 1.0;
        if (n >= 0) begin
            for (int k = 0; k < n; k++) r = r * 2.0;
        end else begin
            for (int k = 0; k < -n; k++) r = r / 2.0;
        end
        return r;
    endfunction

    function automatic real e4m3_val(input int code);
        int ef;
        int mf;
        ef = code / 8;
        mf = code % 8;
        if (ef == 0) return (mf / 8.0) * pow2(-6);
        return (1.0 + mf / 8.0) * pow2(ef - 7);
    endfunction

    // nearest representable e4m3 magnitude, ties to the even code; above 464 rounds past 448
    task automatic ref_cvt(input logic [15:0] a, output logic [7:0] ey, output logic ei,
                           output logic chk_i);
        int  ex;
        int  mt;
        int  best;
        real v;
        real cv;
        real d;
        real bd;
        ex    = int'(a[14:7]);
        mt    = int'(a[6:0]);
        chk_i = 1'b1;
        if (ex == 255 && mt != 0) begin
            ey    = {a[15], 7'h7F};
            ei    = 1'b0;
            chk_i = 1'b0;
        end else if (ex == 255) begin
            ey = {a[15], OVF_MAG};
            ei = 1'b1;
        end else begin
            if (ex == 0) v = mt * pow2(-133);
            else         v = (1.0 + mt / 128.0) * pow2(ex - 127);
            if (v > 464.0) begin
                ey = {a[15], OVF_MAG};
                ei = 1'b1;
            end else begin
                best = 0;
                bd   = v;
                for (int c = 1; c < 127; c++) begin
                    cv = e4m3_val(c);
                    d  = (v > cv) ? v - cv : cv - v;
                    if (d < bd || (d == bd && (c % 2) == 0)) begin
                        best = c;
                        bd   = d;
                    end
                end
                ey = {a[15], 7'(best)};
                ei = (e4m3_val(best) != v);
            end
        end
    endtask

    function automatic logic [15:0] rand_op();
        logic [15:0] r;
        int          sel;
        r   = 16'($urandom);
        sel = int'($urandom_range(0, 9));
        if (sel < 7)       r[14:7] = 8'($urandom_range(108, 138));
        else if (sel == 7) r[14:7] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
        if ($urandom_range(0, 3) == 0) r[2:0] = 3'b000;
        return r;
    endfunction

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        a_bf16    = 16'h3F80;
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (y !== 8'h00) begin n_bad++; $display("FAIL reset_y: got %h want 00", y); end
        n_cmp++;
        if (is_inexact !== 1'b0) begin n_bad++; $display("FAIL reset_inexact: got %b want 0", is_inexact); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [15:0] da [15] = '{16'h3F80, 16'hC000, 16'h4070, 16'h3FFF, 16'h43E0,
                                 16'h43F0, 16'h3B00, 16'h3A80, 16'h3AC0, 16'h8000,
                                 16'h7FC1, 16'h7F80, 16'hFF80, 16'h0001, 16'h3C00};
        logic [7:0]  dy [15] = '{8'h38, 8'hC0, 8'h47, 8'h40, 8'h7E,
                                 {1'b0, OVF_MAG}, 8'h01, 8'h00, 8'h01, 8'h80,
                                 8'h7F, {1'b0, OVF_MAG}, {1'b1, OVF_MAG}, 8'h00, 8'h04};
        logic        di [15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                                 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        dc [15] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        int lat;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            in_valid  = 1'b1;
            a_bf16    = da[i];
            out_ready = 1'b1;
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin n_bad++; $display("FAIL dir_in_ready[%0d]: got %b want 1", i, in_ready); end
            lat = 0;
            for (int c = 1; c <= 8; c++) begin
                @(negedge clock);
                in_valid = 1'b0;
                #1;
                if (out_valid === 1'b1) begin
                    lat = c;
                    break;
                end
            end
            n_cmp++;
            if (lat != 3) begin n_bad++; $display("FAIL dir_latency[%h]: got %0d cycles want 3", da[i], lat); end
            if (lat != 0) begin
                n_cmp++;
                if (y !== dy[i]) begin n_bad++; $display("FAIL dir_y[%h]: got %h want %h", da[i], y, dy[i]); end
                if (dc[i]) begin
                    n_cmp++;
                    if (is_inexact !== di[i]) begin
                        n_bad++;
                        $display("FAIL dir_inexact[%h]: got %b want %b", da[i], is_inexact, di[i]);
                    end
                end
            end
        end
        @(negedge clock);
    endtask

    task automatic test_random_stream();
        logic [7:0] q_y [$];
        logic       q_i [$];
        logic       q_c [$];
        logic [7:0] ey;
        logic       ei;
        logic       ec;
        int         sent;
        int         got;
        localparam int N = 300;
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 4000 && got < N; cyc++) begin
            @(negedge clock);
            in_valid  = (sent < N) && ($urandom_range(0, 4) != 0);
            a_bf16    = rand_op();
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            n_cmp++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                n_bad++;
                $display("FAIL rnd_in_ready: got %b want %b", in_ready, !(out_valid && !out_ready));
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q_y.size() == 0) begin
                    n_bad++;
                    $display("FAIL rnd_spurious: got y=%h with nothing pending, want no output", y);
                end else begin
                    ey = q_y.pop_front();
                    ei = q_i.pop_front();
                    ec = q_c.pop_front();
                    if (y !== ey || (ec && is_inexact !== ei)) begin
                        n_bad++;
                        $display("FAIL rnd_result[%0d]: got y=%h inexact=%b want y=%h inexact=%b",
                                 got, y, is_inexact, ey, ei);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                ref_cvt(a_bf16, ey, ei, ec);
                q_y.push_back(ey);
                q_i.push_back(ei);
                q_c.push_back(ec);
                sent++;
            end
        end
        n_cmp++;
        if (got != N) begin n_bad++; $display("FAIL rnd_count: got %0d results want %0d", got, N); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [15:0] ops [8] = '{16'h3F80, 16'hC000, 16'h4070, 16'h3FFF,
                                 16'h43E0, 16'h3B00, 16'h3AC0, 16'h8000};
        logic [7:0] q_y [$];
        logic       q_i [$];
        logic [7:0] ey;
        logic       ei;
        logic       ec;
        logic       prev_stall;
        logic [7:0] prev_y;
        logic       prev_i;
        int         sent;
        int         got;
        int         stall_seen;
        sent       = 0;
        got        = 0;
        stall_seen = 0;
        prev_stall = 1'b0;
        prev_y     = '0;
        prev_i     = 1'b0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            @(negedge clock);
            in_valid  = (sent < 8);
            a_bf16    = ops[sent % 8];
            out_ready = !(cyc >= 5 && cyc <= 8);
            #1;
            n_cmp++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                n_bad++;
                $display("FAIL b2b_in_ready[%0d]: got %b want %b", cyc, in_ready, !(out_valid && !out_ready));
            end
            if (out_valid && !out_ready && !in_ready) stall_seen++;
            if (prev_stall) begin
                n_cmp++;
                if (out_valid !== 1'b1 || y !== prev_y || is_inexact !== prev_i) begin
                    n_bad++;
                    $display("FAIL b2b_hold[%0d]: got v=%b y=%h i=%b want v=1 y=%h i=%b",
                             cyc, out_valid, y, is_inexact, prev_y, prev_i);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_y     = y;
            prev_i     = is_inexact;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q_y.size() == 0) begin
                    n_bad++;
                    $display("FAIL b2b_spurious: got y=%h with nothing pending, want no output", y);
                end else begin
                    ey = q_y.pop_front();
                    ei = q_i.pop_front();
                    if (y !== ey || is_inexact !== ei) begin
                        n_bad++;
                        $display("FAIL b2b_result[%0d]: got y=%h inexact=%b want y=%h inexact=%b",
                                 got, y, is_inexact, ey, ei);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                ref_cvt(a_bf16, ey, ei, ec);
                q_y.push_back(ey);
                q_i.push_back(ei);
                sent++;
            end
        end
        n_cmp++;
        if (got != 8) begin n_bad++; $display("FAIL b2b_count: got %0d results want 8", got); end
        n_cmp++;
        if (stall_seen == 0) begin n_bad++; $display("FAIL b2b_stall_seen: got 0 stalled cycles want >0"); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset_midflight();
        int lat;
        @(negedge clock);
        in_valid  = 1'b1;
        a_bf16    = 16'h3F80;
        out_ready = 1'b1;
        @(negedge clock);
        a_bf16 = 16'h4070;
        @(negedge clock);
        reset  = 1'b1;
        a_bf16 = 16'hC000;
        @(negedge clock);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || y !== 8'h00) begin
            n_bad++;
            $display("FAIL midrst_state: got v=%b y=%h want v=0 y=00", out_valid, y);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            #1;
            n_cmp++;
            if (out_valid !== 1'b0 || y !== 8'h00) begin
                n_bad++;
                $display("FAIL midrst_drop[%0d]: got v=%b y=%h want v=0 y=00", c, out_valid, y);
            end
        end
        @(negedge clock);
        in_valid = 1'b1;
        a_bf16   = 16'h3F80;
        lat      = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            in_valid = 1'b0;
            #1;
            if (out_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
        n_cmp++;
        if (lat != 3 || y !== 8'h38) begin
            n_bad++;
            $display("FAIL midrst_fresh: got latency=%0d y=%h want latency=3 y=38", lat, y);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        a_bf16    = '0;
        out_ready = 1'b1;
        test_reset();
        test_directed();
        test_random_stream();
        test_back_to_back();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion within time limit, want finish");
        $fatal(1);
    end

endmodule

// File: doc/bf16_to_e4m3_cvt.md
# bf16_to_e4m3_cvt

Pipelined down-converter from bf16 to FP8 e4m3, the inverse of the e4m3 widening path. It sits on the bf16 ALU result path and narrows results to e4m3 before they are stored or fed to the e4m3 ALU. Rounding is round-to-nearest-even (RNE), and e4m3 subnormals are produced. Data moves through a valid/ready handshake with a fixed three-stage pipeline.

## Interface
- No parameters; formats are fixed by the shared package.
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  a_bf16 holds a value to convert
- in_ready  out  1  converter accepts a value this cycle
- a_bf16  in  16  bf16 operand {sign, exp[7:0], mant[6:0]}
- out_valid  out  1  y holds a converted result
- out_ready  in  1  downstream accepts y this cycle
- y  out  8  e4m3 result {sign, exp[3:0], mant[2:0]}
- is_inexact  out  1  rounding discarded nonzero bits (qualified by out_valid)

## Operation
- Unbiased exponent e = exp_bf − 127; target exponent E8 = e + 7.
- bf16 exp == 0 (zero or subnormal): y = {sign, 7'h00}. is_inexact = 1 iff mant ≠ 0.
- bf16 NaN (exp == 0xFF, mant ≠ 0): y = {sign, 7'h7F}.
- bf16 Inf: treated as overflow (see Configuration).
- Normal path, 1 ≤ E8 ≤ 15:
  - Keep mant[6:4].
  - Guard = mant[3], sticky = |mant[2:0].
  - RNE: round up if guard & (sticky | lsb).
  - A mantissa carry increments E8.
- Subnormal path, E8 ≤ 0:
  - Significand {1, mant} is shifted right by (1 − E8); shifts above 9 saturate to 9.
  - Take 3 result bits, then the guard bit and the OR of the rest as sticky.
  - Apply RNE, same rule.
  - A carry into bit 3 yields exponent field 1.
  - A result of 0 yields signed zero.
- Overflow: E8 > 15 after rounding, or encoded magnitude ≥ 0x7F.
- Sign always passes through unchanged, including zero and NaN.

## Timing
- Stage S1 (decode/classify), S2 (align + RNE), S3 (pack/overflow).
- Latency: 3 cycles from the accepting in_valid & in_ready edge to out_valid.
- Throughput: 1 result per cycle when out_ready = 1.
- Global stall: stall = out_valid & ~out_ready.
  - When stalled, all stages hold.
  - in_ready = ~stall (combinational).
- y and is_inexact stay stable while out_valid & ~out_ready.
- Bubbles propagate as invalid stages; they never produce out_valid.
- Simultaneous accept and emit in one cycle is legal and loses nothing.
- Reset values: out_valid = 0, y = 8'h00, is_inexact = 0, all stage valids = 0. in_ready reads 1 once reset deasserts.
- Reset mid-operation:
  - All in-flight values are dropped, with no partial result.
  - in_valid is ignored in any cycle where reset = 1.

## Configuration
- E4M3_SATURATE_EN defined: overflow and Inf produce {sign, 7'h7E} (±448), with is_inexact = 1.
- E4M3_SATURATE_EN undefined: overflow and Inf produce {sign, 7'h7F} (NaN), with is_inexact = 1.
- NaN input gives NaN output in both builds.

## Structure
- Shared package fp_formats_pkg holds:
  - widths and biases: BF16_EXP_W = 8, BF16_MAN_W = 7, BF16_BIAS = 127, E4M3_EXP_W = 4, E4M3_MAN_W = 3, E4M3_BIAS = 7
  - encodings: E4M3_MAX_MAG = 7'h7E, E4M3_NAN_MAG = 7'h7F
  - an S1→S2 classify enum: ZERO, NORMAL, SUBNORM, OVF, NAN
- Sub-module fp_rne_round holds the RNE increment and carry logic: inputs are a kept field plus guard/sticky; outputs are the rounded field, carry and inexact. It is reused by the future e4m3 ALU normaliser.

## Test plan
- 0x3F80 (1.0) → y = 0x38. 0xC000 (−2.0) → y = 0xC0. 0x4070 (3.75) → y = 0x47. All have is_inexact = 0 and each appears exactly 3 cycles after acceptance.
- 0x3FFF → y = 0x40 via mantissa carry with is_inexact = 1. 0x43E0 (448) → y = 0x7E with is_inexact = 0. 0x43F0 (480) → y = 0x7E with E4M3_SATURATE_EN, 0x7F without.
- Subnormals:
  - 0x3B00 (2^-9) → y = 0x01.
  - 0x3A80 (2^-10, tie) → y = 0x00 with is_inexact = 1.
  - 0x3AC0 (1.5·2^-10) → y = 0x01.
  - 0x8000 → y = 0x80.
  - 0x7FC1 → y = 0x7F.
- Back-to-back stream of 8 operands with out_ready held 0 for 4 cycles mid-stream: in_ready drops the same cycle as stall. Then no loss, no duplication, and order is preserved; y is stable while stalled.
- Assert reset with 2 operands in flight: the next cycle after deassertion has out_valid = 0 and y = 0x00. A fresh 0x3F80 then yields 0x38 after 3 cycles.
